seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an NDIGITS common-select 7-segment display.
- Shares one combinational BCD/hex-to-7-segment decoder (val[3:0], dec in, seg[6:0] out) across all digits.
- Sequences the decoder input digit by digit, drives one-hot digit selects with an anti-ghosting blank gap, and double-buffers the displayed word so updates land only on frame boundaries.
- Sits between the system logic that writes display values and the 7-seg pins.

---
 rtl/seg7_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one shared decoder, one-hot digit
// selects with a blank gap between digits, and frame-aligned double buffering.
module seg7_scan_ctrl #(
  parameter int NDIGITS = 4,
  parameter int DWELL   = 1024,
  parameter int BLANK   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_wr,
  input  logic [4*NDIGITS-1:0]   i_word,
  input  logic [NDIGITS-1:0]     i_dp,
  input  logic                   i_lzb,
  output logic [3:0]             o_val,
  output logic                   o_dec,
  output logic [NDIGITS-1:0]     o_digit_en,
  output logic                   o_pending,
  output logic                   o_frame
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NDIGITS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   act_word_q, act_word_d, sh_word_q, sh_word_d;
  logic [NDIGITS-1:0]     act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic                   pend_q, pend_d;
  logic [3:0]             val_q, val_d;
  logic                   dec_q, dec_d;
  logic [NDIGITS-1:0]     den_q, den_d;
  logic                   frame_q, frame_d;
  logic                   commit;
  logic                   lz_run;
  logic [NDIGITS-1:0]     lz_blank;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    act_word_d = act_word_q;
    act_dp_d   = act_dp_q;
    sh_word_d  = sh_word_q;
    sh_dp_d    = sh_dp_q;
    frame_d    = 1'b0;
    commit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        commit = pend_q;
        if (i_en) begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = BLANK_LD;
        end
      end
      S_BLANK: begin
        if (!i_en) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_SHOW;
          cnt_d   = DWELL_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SHOW: begin
        if (!i_en) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_BLANK;
          cnt_d   = BLANK_LD;
          // Last digit done: wrap and commit the shadow at the frame boundary.
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            frame_d = 1'b1;
            commit  = pend_q;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    // Commit reads the old shadow, so a coincident write stays pending.
    if (commit) begin
      act_word_d = sh_word_q;
      act_dp_d   = sh_dp_q;
    end
    pend_d = commit ? i_wr : (pend_q | i_wr);
    if (i_wr) begin
      sh_word_d = i_word;
      sh_dp_d   = i_dp;
    end

    lz_run   = i_lzb;
    lz_blank = '0;
    for (int k = NDIGITS - 1; k > 0; k--) begin
      lz_run      = lz_run & (act_word_d[4*k +: 4] == 4'd0) & ~act_dp_d[k];
      lz_blank[k] = lz_run;
    end

    // Outputs track the next state so they are registered yet aligned with it.
    val_d = '0;
    dec_d = 1'b0;
    den_d = '0;
    if (state_d != S_IDLE) begin
      val_d = act_word_d[{idx_d, 2'b00} +: 4];
      dec_d = act_dp_d[idx_d];
      if (state_d == S_SHOW && !lz_blank[idx_d])
        den_d = NDIGITS'(1) << idx_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      act_word_q <= '0;
      act_dp_q   <= '0;
      sh_word_q  <= '0;
      sh_dp_q    <= '0;
      pend_q     <= 1'b0;
      val_q      <= '0;
      dec_q      <= 1'b0;
      den_q      <= '0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_word_q <= act_word_d;
      act_dp_q   <= act_dp_d;
      sh_word_q  <= sh_word_d;
      sh_dp_q    <= sh_dp_d;
      pend_q     <= pend_d;
      val_q      <= val_d;
      dec_q      <= dec_d;
      den_q      <= den_d;
      frame_q    <= frame_d;
    end
  end

  assign o_val      = val_q;
  assign o_dec      = dec_q;
  assign o_digit_en = den_q;
  assign o_pending  = pend_q;
  assign o_frame    = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: time-based reference model checked every cycle,
// a vector table of static display patterns, and directed corner sequences.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = SLOT * N;

  logic        clk = 1'b0;
  logic        rst_n, en, wr, lzb;
  logic [15:0] word;
  logic [3:0]  dp;
  logic [3:0]  o_val;
  logic        o_dec, o_pending, o_frame;
  logic [3:0]  o_digit_en;

  int checks   = 0;
  int failures = 0;

  seg7_scan_ctrl #(.NDIGITS(N), .DWELL(DW), .BLANK(BL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_wr(wr), .i_word(word),
    .i_dp(dp), .i_lzb(lzb), .o_val(o_val), .o_dec(o_dec),
    .o_digit_en(o_digit_en), .o_pending(o_pending), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  // Reference model: scan position is just cycles since enable, mod one frame.
  bit          m_run, m_frame, m_pend, m_lzb;
  int          m_t;
  logic [15:0] m_aw, m_sw;
  logic [3:0]  m_ad, m_sd;

  function automatic bit m_blanked(int d);
    if (!m_lzb || d == 0) return 1'b0;
    for (int j = d; j < N; j++)
      if (m_aw[4*j +: 4] != 4'd0 || m_ad[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit commit;
    commit  = 1'b0;
    m_frame = 1'b0;
    m_lzb   = lzb;
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_pend = 0;
      m_aw = '0; m_sw = '0; m_ad = '0; m_sd = '0;
      return;
    end
    if (!m_run) begin
      commit = m_pend;
      if (en) begin m_run = 1; m_t = 0; end
    end else if (!en) begin
      m_run = 0;
    end else begin
      m_t = (m_t + 1) % FRAME;
      if (m_t == 0) begin m_frame = 1; commit = m_pend; end
    end
    if (commit) begin m_aw = m_sw; m_ad = m_sd; end
    m_pend = commit ? wr : (m_pend | wr);
    if (wr) begin m_sw = word; m_sd = dp; end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    int d;
    logic [3:0] exp_den;
    @(posedge clk);
    model_step();
    #1;
    exp_den = '0;
    if (m_run) begin
      d = m_t / SLOT;
      if ((m_t % SLOT) >= BL && !m_blanked(d)) exp_den = 4'(1 << d);
      chk("model_val", 32'(o_val), 32'(m_aw[4*d +: 4]));
      chk("model_dec", 32'(o_dec), 32'(m_ad[d]));
    end
    chk("model_digit_en", 32'(o_digit_en), 32'(exp_den));
    chk("model_pending", 32'(o_pending), 32'(m_pend));
    chk("model_frame", 32'(o_frame), 32'(m_frame));
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (!(m_run && m_t == target) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("run_to_timeout", 32'(n), 32'(0));
  endtask

  typedef struct {
    logic [15:0] w;
    logic [3:0]  dp;
    logic        lzb;
    logic [3:0]  lit;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int frames;
    logic [15:0] vw;
    logic [3:0]  vd, vl;
    rst_n = 0; en = 0; wr = 0; lzb = 0; word = '0; dp = '0;

    tbl[0] = '{16'h1234, 4'b0100, 1'b0, 4'b1111};
    tbl[1] = '{16'h0050, 4'b0000, 1'b1, 4'b0011};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1, 4'b0001};
    tbl[3] = '{16'h0000, 4'b1000, 1'b1, 4'b1111};
    tbl[4] = '{16'h0F00, 4'b0000, 1'b1, 4'b0111};
    tbl[5] = '{16'h0000, 4'b0010, 1'b1, 4'b0011};
    tbl[6] = '{16'hA0B0, 4'b0000, 1'b1, 4'b1111};
    tbl[7] = '{16'h00C0, 4'b0000, 1'b0, 4'b1111};

    // Reset state and basic scan timing.
    tick(); tick();
    chk("rst_digit_en", 32'(o_digit_en), 0);
    chk("rst_val", 32'(o_val), 0);
    chk("rst_pending", 32'(o_pending), 0);
    rst_n = 1; en = 1;
    tick(); chk("t1_blank0", 32'(o_digit_en), 0);
    tick(); chk("t1_blank1", 32'(o_digit_en), 0);
    tick(); chk("t1_show0_first", 32'(o_digit_en), 32'h1);
    for (int i = 0; i < 7; i++) tick();
    chk("t1_show0_last", 32'(o_digit_en), 32'h1);
    tick(); chk("t1_gap", 32'(o_digit_en), 0);
    tick(); tick(); chk("t1_show1", 32'(o_digit_en), 32'h2);
    frames = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (o_frame) frames++;
    end
    chk("t1_frame_count", 32'(frames), 2);

    // Static patterns from the vector table, including leading-zero blanking.
    for (int v = 0; v < 8; v++) begin
      vw = tbl[v].w; vd = tbl[v].dp; vl = tbl[v].lit;
      en = 0; tick();
      wr = 1; word = vw; dp = vd; lzb = tbl[v].lzb;
      tick();
      chk("vec_pending_set", 32'(o_pending), 1);
      wr = 0; en = 1;
      tick();
      chk("vec_pending_clr", 32'(o_pending), 0);
      for (int k = 0; k < N; k++) begin
        run_to(k * SLOT + BL);
        chk("vec_digit_en", 32'(o_digit_en), vl[k] ? 32'(1 << k) : 32'd0);
        chk("vec_val", 32'(o_val), 32'(vw[4*k +: 4]));
        chk("vec_dec", 32'(o_dec), 32'(vd[k]));
      end
    end

    // Mid-frame write lands only after the frame commit.
    en = 0; lzb = 0; tick();
    wr = 1; word = 16'h1234; dp = 4'b0100; tick(); wr = 0; en = 1; tick();
    run_to(SLOT + BL);
    wr = 1; word = 16'h5678; dp = 4'b0000; tick(); wr = 0;
    chk("mid_pending", 32'(o_pending), 1);
    run_to(2 * SLOT + BL);
    chk("mid_d2_val", 32'(o_val), 2);
    chk("mid_d2_dec", 32'(o_dec), 1);
    run_to(3 * SLOT + BL);
    chk("mid_d3_val", 32'(o_val), 1);
    run_to(0);
    chk("mid_frame", 32'(o_frame), 1);
    run_to(BL);
    chk("mid_d0_new", 32'(o_val), 8);
    chk("mid_pending_clr", 32'(o_pending), 0);

    // Write coinciding with the commit edge.
    wr = 1; word = 16'hAAAA; tick(); wr = 0;
    run_to(FRAME - 1);
    wr = 1; word = 16'h9999; tick(); wr = 0;
    chk("coinc_frame", 32'(o_frame), 1);
    chk("coinc_pending", 32'(o_pending), 1);
    run_to(BL);
    chk("coinc_val_a", 32'(o_val), 32'hA);
    run_to(FRAME - 1); tick();
    chk("coinc_pending_clr", 32'(o_pending), 0);
    run_to(BL);
    chk("coinc_val_9", 32'(o_val), 9);

    // Disable during digit 2, re-enable, then reset mid-SHOW.
    run_to(2 * SLOT + BL + 3);
    en = 0; tick();
    chk("dis_digit_en", 32'(o_digit_en), 0);
    chk("dis_frame", 32'(o_frame), 0);
    en = 1;
    tick(); chk("reen_blank0", 32'(o_digit_en), 0);
    tick(); chk("reen_blank1", 32'(o_digit_en), 0);
    tick(); chk("reen_show0", 32'(o_digit_en), 1);
    run_to(SLOT + BL + 2);
    wr = 1; word = 16'h4321; tick(); wr = 0;
    rst_n = 0; tick();
    chk("mrst_digit_en", 32'(o_digit_en), 0);
    chk("mrst_val", 32'(o_val), 0);
    chk("mrst_dec", 32'(o_dec), 0);
    chk("mrst_pending", 32'(o_pending), 0);
    chk("mrst_frame", 32'(o_frame), 0);
    rst_n = 1;

    // Randomized traffic against the model.
    en = 1;
    for (int i = 0; i < 3000; i++) begin
      wr = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0: word = 16'($urandom);
        1: word = 16'($urandom) & 16'h00FF;
        2: word = 16'($urandom) & 16'h000F;
        default: word = 16'($urandom) & 16'h0F0F;
      endcase
      dp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 79) == 0) en = ~en;
      if ($urandom_range(0, 299) == 0) lzb = 1'($urandom);
      rst_n = ($urandom_range(0, 699) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
